// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: forward select codes, FSM states and counter width shared by the hazard unit
package hazard_ctrl_pkg;
  localparam int CNT_W = 16;
  localparam logic [1:0] FWD_RF    = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;
  typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/hazard_match.sv
// hazard_match: matches one decode source against the EX/MEM shadow producers and picks its forward source
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic       i_valid,
  input  logic       i_used,
  input  logic [4:0] i_src,
  input  logic [4:0] i_ex_rd,
  input  logic       i_ex_wr,
  input  logic [4:0] i_mem_rd,
  input  logic       i_mem_wr,
  output logic [1:0] o_sel
);
  logic w_live, w_ex_hit, w_mem_hit;
  assign w_live    = i_valid & i_used & (i_src != 5'd0);
  assign w_ex_hit  = w_live & i_ex_wr & (i_ex_rd == i_src);
  assign w_mem_hit = w_live & i_mem_wr & (i_mem_rd == i_src);
  assign o_sel     = w_ex_hit ? FWD_EXMEM : w_mem_hit ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/RAW stall, redirect flush and forward selects; define HAZARD_FORWARDING_EN to enable forwarding
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_redirect,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  state_t r_state, w_next;
  logic [4:0] r_ex_rd, r_mem_rd;
  logic r_ex_wr, r_mem_wr, w_hazard, w_stall;
  logic [1:0] w_sel_a, w_sel_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  hazard_match u_match_a (
    .i_valid(id_valid), .i_used(id_rs1_used), .i_src(id_rs1),
    .i_ex_rd(r_ex_rd), .i_ex_wr(r_ex_wr), .i_mem_rd(r_mem_rd), .i_mem_wr(r_mem_wr),
    .o_sel(w_sel_a)
  );
  hazard_match u_match_b (
    .i_valid(id_valid), .i_used(id_rs2_used), .i_src(id_rs2),
    .i_ex_rd(r_ex_rd), .i_ex_wr(r_ex_wr), .i_mem_rd(r_mem_rd), .i_mem_wr(r_mem_wr),
    .o_sel(w_sel_b)
  );
`ifdef HAZARD_FORWARDING_EN
  logic r_ex_load;
  logic [1:0] r_fwd_a, r_fwd_b;
  assign w_hazard = r_ex_load & ((w_sel_a == FWD_EXMEM) | (w_sel_b == FWD_EXMEM));
  // a bubble entering EX (stall, redirect or reset) carries no forwarding
  always_ff @(posedge clk) begin
    r_ex_load <= ~id_ex_bubble & id_valid & id_mem_read;
    r_fwd_a   <= id_ex_bubble ? FWD_RF : w_sel_a;
    r_fwd_b   <= id_ex_bubble ? FWD_RF : w_sel_b;
  end
  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
`else
  logic w_unused;
  assign w_unused  = id_mem_read;
  assign w_hazard  = (w_sel_a != FWD_RF) | (w_sel_b != FWD_RF);
  assign fwd_a_sel = FWD_RF;
  assign fwd_b_sel = FWD_RF;
`endif
  assign w_stall        = w_hazard & ~ex_redirect & ~reset;
  assign pc_write_en    = ~w_stall;
  assign if_id_write_en = ~w_stall;
  assign if_id_flush    = ex_redirect & ~reset;
  assign id_ex_bubble   = reset | ex_redirect | w_hazard;
  assign stall_count    = r_stall_cnt;
  assign flush_count    = r_flush_cnt;
  always_comb begin
    w_next = ST_RUN;
    w_next = ex_redirect ? ST_FLUSH : (r_state == ST_FLUSH || !w_hazard) ? ST_RUN : ST_STALL;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_ex_rd     <= 5'd0;
      r_ex_wr     <= 1'b0;
      r_mem_rd    <= 5'd0;
      r_mem_wr    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_next;
      r_ex_rd     <= id_ex_bubble ? 5'd0 : id_rd;
      r_ex_wr     <= ~id_ex_bubble & id_valid & id_reg_write;
      r_mem_rd    <= r_ex_rd;
      r_mem_wr    <= r_ex_wr;
      if (w_stall) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (ex_redirect) r_flush_cnt <= sat_inc(r_flush_cnt);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed cases plus random traffic checked against an in-bench producer-history model
module tb_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 1'b0, id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic id_reg_write = 1'b0, id_mem_read = 1'b0, ex_redirect = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_count, flush_count;
  int n_vec = 0, n_bad = 0;
  bit live = 1'b0;
`ifdef HAZARD_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  typedef struct {int rd; bit wr; bit ld;} prod_t;
  prod_t prod[2];
  int m_fwd_a = 0, m_fwd_b = 0, m_stall = 0, m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_redirect(ex_redirect), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // youngest producer (entered EX last) is prod[0]; a match there beats an older one
  function automatic int sel_of(input logic [4:0] src, input logic used);
    if (!id_valid || !used || src == 5'd0) return 0;
    if (prod[0].wr && prod[0].rd == int'(src)) return 1;
    if (prod[1].wr && prod[1].rd == int'(src)) return 2;
    return 0;
  endfunction

  function automatic bit hazard();
    int a, b;
    a = sel_of(id_rs1, id_rs1_used);
    b = sel_of(id_rs2, id_rs2_used);
    return FWD ? (prod[0].ld && (a == 1 || b == 1)) : (a != 0 || b != 0);
  endfunction

  // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble}
  function automatic logic [3:0] exp_ctl();
    if (reset) return 4'b1101;
    if (ex_redirect) return 4'b1111;
    if (hazard()) return 4'b0001;
    return 4'b1100;
  endfunction

  always @(posedge clk) begin
    logic [3:0] c;
    bit h;
    if (reset) begin
      prod[0] = '{0, 1'b0, 1'b0};
      prod[1] = '{0, 1'b0, 1'b0};
      m_fwd_a = 0; m_fwd_b = 0; m_stall = 0; m_flush = 0;
      live = 1'b1;
    end else begin
      c = exp_ctl();
      h = hazard();
      m_fwd_a = (FWD && !c[0]) ? sel_of(id_rs1, id_rs1_used) : 0;
      m_fwd_b = (FWD && !c[0]) ? sel_of(id_rs2, id_rs2_used) : 0;
      if (!ex_redirect && h) m_stall = (m_stall == 65535) ? 65535 : m_stall + 1;
      if (ex_redirect) m_flush = (m_flush == 65535) ? 65535 : m_flush + 1;
      prod[1] = prod[0];
      prod[0] = c[0] ? '{0, 1'b0, 1'b0} : '{int'(id_rd), id_valid && id_reg_write, id_valid && id_mem_read};
    end
  end

  always @(negedge clk) begin
    logic [3:0] c;
    if (live) begin
      c = exp_ctl();
      chk("pc_write_en", pc_write_en, c[3]);
      chk("if_id_write_en", if_id_write_en, c[2]);
      chk("if_id_flush", if_id_flush, c[1]);
      chk("id_ex_bubble", id_ex_bubble, c[0]);
      chk("fwd_a_sel", fwd_a_sel, m_fwd_a);
      chk("fwd_b_sel", fwd_b_sel, m_fwd_b);
      chk("stall_count", stall_count, m_stall);
      chk("flush_count", flush_count, m_flush);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1_used = 0; id_rs2_used = 0; id_reg_write = 0;
    id_mem_read = 0; ex_redirect = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
  endtask

  task automatic instr(input int rd, input int rs1, input int rs2, input bit wr, input bit ld);
    id_valid = 1; id_rd = rd[4:0]; id_rs1 = rs1[4:0]; id_rs2 = rs2[4:0];
    id_rs1_used = 1; id_rs2_used = 1; id_reg_write = wr; id_mem_read = ld;
  endtask

  task automatic do_reset();
    reset = 1;
    idle();
    tick();
    tick();
    reset = 0;
  endtask

  // holds the decode instruction until it is allowed into EX; bounded
  task automatic issue_hold(output int stalls);
    stalls = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (pc_write_en === 1'b1) break;
      stalls++;
      tick();
    end
  endtask

  task automatic use_after(input bit ld, output int stalls);
    instr(5, 1, 2, 1, ld);
    tick();
    instr(6, 5, 5, 1, 0);
    issue_hold(stalls);
    tick();
    idle();
    #2;
  endtask

  initial begin
    int s;
    do_reset();
    #2;
    chk("rst stall_count", stall_count, 0);
    chk("rst flush_count", flush_count, 0);
    chk("rst fwd_a", fwd_a_sel, 0);
    chk("rst pc_write_en", pc_write_en, 1);
    chk("rst bubble", id_ex_bubble, 0);
    tick();
    instr(5, 1, 2, 1, 0);
    tick();
    instr(6, 5, 7, 1, 0);
    issue_hold(s);
    chk("alu stalls", s, FWD ? 0 : 2);
    tick();
    idle();
    #2;
    chk("alu fwd_a", fwd_a_sel, FWD ? 1 : 0);
    chk("alu fwd_b", fwd_b_sel, 0);
    chk("alu stall_count", stall_count, FWD ? 0 : 2);
    do_reset();
    use_after(1'b1, s);
    chk("ld stalls", s, FWD ? 1 : 2);
    chk("ld fwd_a", fwd_a_sel, FWD ? 2 : 0);
    chk("ld fwd_b", fwd_b_sel, FWD ? 2 : 0);
    chk("ld stall_count", stall_count, FWD ? 1 : 2);
    do_reset();
    instr(0, 1, 2, 1, 0);
    tick();
    instr(6, 0, 0, 1, 0);
    #2;
    chk("x0 pc_write_en", pc_write_en, 1);
    tick();
    idle();
    #2;
    chk("x0 fwd_a", fwd_a_sel, 0);
    chk("x0 fwd_b", fwd_b_sel, 0);
    do_reset();
    instr(5, 1, 1, 1, 1);
    tick();
    instr(6, 5, 5, 1, 0);
    ex_redirect = 1;
    #2;
    chk("redir flush", if_id_flush, 1);
    chk("redir pc_write_en", pc_write_en, 1);
    chk("redir if_id_write_en", if_id_write_en, 1);
    chk("redir bubble", id_ex_bubble, 1);
    tick();
    idle();
    #2;
    chk("redir flush_count", flush_count, 1);
    chk("redir stall_count", stall_count, 0);
    do_reset();
    force dut.r_stall_cnt = 16'hFFFE;
    m_stall = 65534;
    #1;
    release dut.r_stall_cnt;
    tick();
    use_after(1'b1, s);
    chk("sat first", stall_count, 16'hFFFF);
    use_after(1'b1, s);
    chk("sat hold", stall_count, 16'hFFFF);
    instr(5, 1, 1, 1, 1);
    tick();
    instr(6, 5, 5, 1, 0);
    reset = 1;
    #2;
    chk("midrst pc_write_en", pc_write_en, 1);
    chk("midrst bubble", id_ex_bubble, 1);
    tick();
    reset = 0;
    idle();
    #2;
    chk("midrst stall_count", stall_count, 0);
    chk("midrst pc_write_en after", pc_write_en, 1);
    chk("midrst bubble after", id_ex_bubble, 0);
    for (int i = 0; i < 3000; i++) begin
      id_valid     = $urandom_range(0, 3) != 0;
      id_rs1       = 5'($urandom_range(0, 7));
      id_rs2       = 5'($urandom_range(0, 7));
      id_rd        = 5'($urandom_range(0, 7));
      id_rs1_used  = $urandom_range(0, 3) != 0;
      id_rs2_used  = $urandom_range(0, 1) != 0;
      id_reg_write = $urandom_range(0, 3) != 0;
      id_mem_read  = $urandom_range(0, 2) == 0;
      ex_redirect  = $urandom_range(0, 15) == 0;
      reset        = $urandom_range(0, 199) == 0;
      tick();
    end
    reset = 0;
    idle();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode stage holds a real instruction
- id_rs1, id_rs2  in  5 each  decode source registers
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  5  decode destination
- id_reg_write  in  1  decode instruction writes rd
- id_mem_read  in  1  decode instruction is a load
- ex_redirect  in  1  EX resolved taken branch/jal/jalr
- pc_write_en  out  1  PC may advance
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  IF/ID loads a bubble
- id_ex_bubble  out  1  ID/EX loads all-zero control
- fwd_a_sel, fwd_b_sel  out  2 each  EX operand source: 0 regfile, 1 EX/MEM result, 2 MEM/WB result; 3 never driven
- stall_count, flush_count  out  16 each  saturating event counters

Function
REQ-003 Block SHALL keep a shadow pipeline of producers: EX slot {rd, wr, load}, MEM slot {rd, wr}; each slot shifts one stage per clk.
REQ-004 EX slot SHALL load the decode tuple when ID/EX advances with a real instruction, and all-zero when id_ex_bubble=1.
REQ-005 A producer with rd=0 or wr=0 SHALL never create a hazard or forward.
REQ-006 Source match SHALL require srcN_used=1, id_valid=1, srcN==slot rd, srcN!=0.
REQ-007 Load-use hazard: EX slot load=1 and matches either used source -> stall.
REQ-008 Stall cycle SHALL drive pc_write_en=0, if_id_write_en=0, id_ex_bubble=1, if_id_flush=0.
REQ-009 Redirect cycle (ex_redirect=1) SHALL drive if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1; redirect SHALL take priority over any stall in the same cycle.
REQ-010 Otherwise: pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=0.
REQ-011 Forward selects SHALL be computed in ID and registered, valid during the consumer's EX cycle: EX-slot match -> 1; else MEM-slot match -> 2; else 0; EX slot has priority.
REQ-012 Registered selects SHALL be 0 for any cycle following a stall or redirect bubble.
REQ-013 Register file is write-through; a producer in WB SHALL create no hazard.
REQ-014 State machine SHALL be RUN, STALL, FLUSH: RUN->STALL on hazard; STALL->RUN when hazard clears; any state->FLUSH on ex_redirect; FLUSH->RUN next cycle unless ex_redirect reasserts.
REQ-015 stall_count SHALL increment once per STALL cycle, flush_count once per redirect cycle; both SHALL saturate at 0xFFFF.

Reset
REQ-016 While reset=1 at clk: shadow slots zero, state RUN, fwd selects 0, both counters 0.
REQ-017 During reset cycles, outputs SHALL be pc_write_en=1, if_id_write_en=1, if_id_flush=0, id_ex_bubble=1.
REQ-018 Reset asserted mid-stall SHALL abandon the stall with no counter update that cycle.

Configuration
REQ-019 Macro HAZARD_FORWARDING_EN SHALL select forwarding.
REQ-020 Defined: behaviour per REQ-007 and REQ-011; load-use stall is exactly 1 cycle.
REQ-021 Undefined: any EX- or MEM-slot match stalls (up to 2 cycles); fwd_a_sel and fwd_b_sel tied to 0.

Structure
REQ-022 Shared package SHALL hold fwd select encodings (FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2), state encodings, and counter width 16.
REQ-023 One sub-module, hazard_match, SHALL compute the match and select for one source operand; instantiated twice.

Verification
REQ-024 Bench SHALL cover:
- add x5 then sub x6,x5,x7 back-to-back (fwd on) -> no stall, fwd_a_sel=1 in sub's EX cycle.
- lw x5 then add x6,x5,x5 -> one stall, stall_count=1, then fwd_a_sel=2 and fwd_b_sel=2.
- add x0,... then use x0 -> no stall, selects 0.
- ex_redirect=1 in same cycle as a load-use hazard -> if_id_flush=1, pc_write_en=1, flush_count=1, stall_count unchanged.
- fwd off: add x5 then add x6,x5,x1 -> two stall cycles, selects 0, stall_count=2.
- stall_count preloaded to 0xFFFF by 65535 stalls, one more -> stays 0xFFFF; reset mid-stall -> counters 0, state RUN.
